// File: rtl/bus_requester.sv
// Requester side of the bus arbiter handshake: one command at a time,
// 1-3 beats on grant, optional bus hold, timeout recovery with retries.
module bus_requester #(
  parameter int HOLD_W    = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [1:0]                     i_cmd_beats,
  input  logic [HOLD_W-1:0]              i_cmd_hold,
  input  logic                           i_beat_stall,
  input  logic                           i_gnt,
  input  logic                           i_tout,
  output logic                           o_req,
  output logic                           o_done,
  output logic                           o_dly,
  output logic                           o_reset,
  output logic                           o_beat_en,
  output logic                           o_xfer_ok,
  output logic                           o_xfer_err,
  output logic [$clog2(MAX_RETRY+1)-1:0] o_retry_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    HOLD,
    RECOVER
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_beats;
  logic [1:0]        r_beat_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [RW-1:0]     r_retry;
  logic              r_ok;
  logic              r_err;

  logic w_active;
  logic w_beat;
  logic w_last;
  logic w_hold_nz;
  logic w_can_retry;
  logic w_hold_end;

  assign w_active    = (r_state == REQ) || (r_state == XFER);
  assign w_beat      = w_active & i_gnt & ~i_beat_stall & ~i_tout;
  assign w_last      = w_beat & (r_beat_cnt == r_beats - 2'd1);
  assign w_hold_nz   = (r_hold != '0);
  assign w_can_retry = (r_retry < MAXR);
  assign w_hold_end  = (r_state == HOLD) && (r_hold_cnt == HOLD_W'(1));

  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_req       = 1'b0;
    o_done      = 1'b0;
    o_dly       = 1'b0;
    o_reset     = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_next = REQ;
      end
      REQ, XFER: begin
        o_req = (r_state == REQ);
        // timeout wins over any grant or stall in the same cycle
        if (i_tout) begin
          w_next = RECOVER;
        end else if (w_last) begin
          o_done = 1'b1;
          o_dly  = w_hold_nz;
          w_next = w_hold_nz ? HOLD : IDLE;
        end else if (i_gnt) begin
          w_next = XFER;
        end
      end
      HOLD: begin
        o_dly = 1'b1;
        if (w_hold_end) w_next = IDLE;
      end
      RECOVER: begin
        o_reset = 1'b1;
        w_next  = w_can_retry ? REQ : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_beats    <= 2'd1;
      r_beat_cnt <= '0;
      r_hold     <= '0;
      r_hold_cnt <= '0;
      r_retry    <= '0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ok    <= (w_last & ~w_hold_nz) | w_hold_end;
      r_err   <= (r_state == RECOVER) & ~w_can_retry;
      if (r_state == IDLE && i_cmd_valid) begin
        r_beats    <= (i_cmd_beats == 2'd0) ? 2'd1 : i_cmd_beats;
        r_hold     <= i_cmd_hold;
        r_retry    <= '0;
        r_beat_cnt <= '0;
      end
      if (w_beat) r_beat_cnt <= r_beat_cnt + 2'd1;
      if (w_last) r_hold_cnt <= r_hold;
      if (r_state == HOLD) r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      if (r_state == RECOVER && w_can_retry) begin
        r_retry    <= r_retry + RW'(1);
        r_beat_cnt <= '0;
      end
    end
  end

  assign o_beat_en   = w_beat;
  assign o_xfer_ok   = r_ok;
  assign o_xfer_err  = r_err;
  assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester; output vector order is
// {cmd_ready, req, done, dly, reset, beat_en, xfer_ok, xfer_err}.
module tb_bus_requester;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_beats;
  logic [3:0] cmd_hold;
  logic       beat_stall;
  logic       gnt;
  logic       tout;
  logic       req;
  logic       done;
  logic       dly;
  logic       rst_o;
  logic       beat_en;
  logic       xfer_ok;
  logic       xfer_err;
  logic [1:0] retry_cnt;
  logic [7:0] ov;

  int total = 0;
  int bad   = 0;

  bus_requester #(.HOLD_W(4), .MAX_RETRY(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_beats  (cmd_beats),
    .i_cmd_hold   (cmd_hold),
    .i_beat_stall (beat_stall),
    .i_gnt        (gnt),
    .i_tout       (tout),
    .o_req        (req),
    .o_done       (done),
    .o_dly        (dly),
    .o_reset      (rst_o),
    .o_beat_en    (beat_en),
    .o_xfer_ok    (xfer_ok),
    .o_xfer_err   (xfer_err),
    .o_retry_cnt  (retry_cnt)
  );

  assign ov = {cmd_ready, req, done, dly, rst_o, beat_en, xfer_ok, xfer_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ck(input string tag, input logic [7:0] o,
                    input logic [7:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic g, input logic s, input logic t);
    gnt        = g;
    beat_stall = s;
    tout       = t;
    #1;
  endtask

  task automatic accept(input logic [1:0] b, input logic [3:0] h);
    cmd_valid = 1'b1;
    cmd_beats = b;
    cmd_hold  = h;
    #1;
    ck("accept_ready", ov, 8'b1000_0000);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_beats  = 2'd0;
    cmd_hold   = 4'd0;
    beat_stall = 1'b0;
    gnt        = 1'b0;
    tout       = 1'b0;
    #12;
    ck("rst_outs", ov, 8'b1000_0000);
    ck("rst_retry", {6'd0, retry_cnt}, 8'd0);
    rst_n = 1'b1;
    step();

    // 1 beat, no hold, grant arrives two cycles after req
    accept(2'd1, 4'd0);
    drv(0, 0, 0); ck("a_req0", ov, 8'b0100_0000);
    step();       ck("a_req1", ov, 8'b0100_0000);
    step();
    drv(1, 0, 0); ck("a_done", ov, 8'b0110_0100);
    step();
    drv(0, 0, 0); ck("a_ok", ov, 8'b1000_0010);
    step();       ck("a_idle", ov, 8'b1000_0000);

    // 3 beats, hold 2: dly over done + 2 hold cycles
    accept(2'd3, 4'd2);
    drv(1, 0, 0); ck("b_beat1", ov, 8'b0100_0100);
    step();       ck("b_beat2", ov, 8'b0000_0100);
    step();       ck("b_beat3", ov, 8'b0011_0100);
    step();
    drv(0, 0, 0); ck("b_hold1", ov, 8'b0001_0000);
    step();       ck("b_hold2", ov, 8'b0001_0000);
    step();       ck("b_ok", ov, 8'b1000_0010);
    step();       ck("b_idle", ov, 8'b1000_0000);

    // stall on 2nd grant, timeout on 3rd, clean retry
    accept(2'd3, 4'd0);
    drv(1, 0, 0); ck("c_beat1", ov, 8'b0100_0100);
    step();
    drv(1, 1, 0); ck("c_stall", ov, 8'b0000_0000);
    step();
    drv(1, 0, 1); ck("c_tout", ov, 8'b0000_0000);
    step();
    drv(0, 0, 0); ck("c_recover", ov, 8'b0000_1000);
    step();       ck("c_rereq", ov, 8'b0100_0000);
    ck("c_retry1", {6'd0, retry_cnt}, 8'd1);
    drv(1, 0, 0); ck("c_r1", ov, 8'b0100_0100);
    step();       ck("c_r2", ov, 8'b0000_0100);
    step();       ck("c_r3", ov, 8'b0010_0100);
    step();
    drv(0, 0, 0); ck("c_ok", ov, 8'b1000_0010);

    // three timeouts exhaust retries
    step();
    accept(2'd3, 4'd0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0); ck("d_beat", ov, 8'b0100_0100);
      step();
      drv(1, 1, 0); step();
      drv(1, 0, 1); ck("d_tout", ov, 8'b0000_0000);
      step();
      drv(0, 0, 0); ck("d_recover", ov, 8'b0000_1000);
      ck("d_retry", {6'd0, retry_cnt}, 8'(i));
      step();
      if (i < 2) begin
        ck("d_rereq", ov, 8'b0100_0000);
        ck("d_retry_inc", {6'd0, retry_cnt}, 8'(i + 1));
      end
    end
    ck("d_err", ov, 8'b1000_0001);
    step();
    ck("d_err_once", ov, 8'b1000_0000);

    // async reset during hold
    accept(2'd1, 4'd3);
    drv(1, 0, 0); ck("e_done", ov, 8'b0111_0100);
    step();
    drv(0, 0, 0); ck("e_hold", ov, 8'b0001_0000);
    rst_n = 1'b0;
    #1;
    ck("e_rst", ov, 8'b1000_0000);
    step();
    rst_n = 1'b1;
    step();       ck("e_idle", ov, 8'b1000_0000);
    step();       ck("e_no_ok", ov, 8'b1000_0000);

    // beats=0 acts as 1; back-to-back accept in xfer_ok cycle
    accept(2'd0, 4'd0);
    drv(1, 0, 0); ck("f_done1", ov, 8'b0110_0100);
    step();
    drv(0, 0, 0);
    cmd_valid = 1'b1;
    #1;
    ck("f_ok_accept", ov, 8'b1000_0010);
    step();
    cmd_valid = 1'b0;
    #1;
    ck("f_req", ov, 8'b0100_0000);
    drv(1, 0, 0); ck("f_done2", ov, 8'b0110_0100);
    step();
    drv(0, 0, 0); ck("f_ok2", ov, 8'b1000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
